conv: RTL and testbench

Fixed-kernel 3x3 2-D convolution engine for a 6x6 tile of signed 8-bit pixels, producing a 4x4 "valid" result of signed 20-bit values. Pixels stream in serially, one per clock. The block computes all 16 outputs internally, pulses a finish flag, then streams the results out serially. It sits as a leaf compute block between a pixel source and a result sink that share one clock.

---
 rtl/conv.sv | 154 +++++++++++++++
 tb/tb_conv.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv.sv
// -----------------------------------------------------------------------------
// conv : fixed-kernel 3x3 2-D correlation engine for a 6x6 tile of signed
//        8-bit pixels, producing a 4x4 "valid" result of signed 20-bit values.
//
// Pixels stream in one per clock while the block is loading. Once all 36 are
// held, one result per cycle is computed into a 16-entry buffer. A one-cycle
// finish pulse follows, and then the 16 results stream out in raster order.
//
// Parameters:
//   K11..K33     signed 8-bit kernel coefficients, row-major
//                (defaults form a horizontal Sobel-like kernel)
//
// Ports:
//   clk          sole clock, rising edge
//   reset        synchronous, active-low
//   CONV_start   pixel valid; CONV_iData captured while idle/loading
//   CONV_iData   signed 8-bit pixel, raster order
//   CONV_finish  one-cycle pulse; result stream starts on the next cycle
//   CONV_oData   signed 20-bit result stream, 0 when not streaming
//
// Build option:
//   CONV_RELU_EN when defined, negative results are clamped to 0 before they
//                are stored; timing is unchanged.
// -----------------------------------------------------------------------------
module conv #(
    parameter logic signed [7:0] K11 = 8'sd1,
    parameter logic signed [7:0] K12 = 8'sd0,
    parameter logic signed [7:0] K13 = -8'sd1,
    parameter logic signed [7:0] K21 = 8'sd2,
    parameter logic signed [7:0] K22 = 8'sd0,
    parameter logic signed [7:0] K23 = -8'sd2,
    parameter logic signed [7:0] K31 = 8'sd1,
    parameter logic signed [7:0] K32 = 8'sd0,
    parameter logic signed [7:0] K33 = -8'sd1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               CONV_start,
    input  logic signed [7:0]  CONV_iData,
    output logic               CONV_finish,
    output logic signed [19:0] CONV_oData
);

    typedef enum logic [2:0] {IDLE, LOAD, CALC, FIN, OUT} state_t;

    localparam logic signed [7:0] KERN [9] = '{K11, K12, K13,
                                               K21, K22, K23,
                                               K31, K32, K33};

    state_t state;
    state_t state_next;

    logic        [5:0]  pix_cnt;
    logic        [4:0]  out_cnt;
    logic signed [7:0]  pix [36];
    logic signed [19:0] res [16];

    logic               capture;
    logic signed [19:0] acc;
    logic signed [19:0] res_val;
    logic signed [15:0] prod;
    logic        [5:0]  pix_idx;
    logic        [3:0]  kern_idx;

    // The first pixel of a frame is taken on the same edge that leaves IDLE,
    // so capture is allowed in both IDLE and LOAD.
    assign capture = CONV_start && ((state == IDLE) || (state == LOAD));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (CONV_start) state_next = LOAD;
            LOAD: if (CONV_start && (pix_cnt == 6'd35)) state_next = CALC;
            CALC: if (out_cnt == 5'd15) state_next = FIN;
            FIN:  state_next = OUT;
            OUT:  if (out_cnt == 5'd16) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // One output per cycle: out_cnt[3:2] is the result row and out_cnt[1:0]
    // the result column, so the window's top-left pixel is row*6 + col.
    always_comb begin
        acc      = '0;
        prod     = '0;
        pix_idx  = '0;
        kern_idx = '0;
        for (int m = 0; m < 3; m++) begin
            for (int n = 0; n < 3; n++) begin
                pix_idx  = 6'((int'(out_cnt[3:2]) + m) * 6 + int'(out_cnt[1:0]) + n);
                kern_idx = 4'(m * 3 + n);
                prod     = 16'(KERN[kern_idx]) * 16'(pix[pix_idx]);
                acc      = acc + $signed({{4{prod[15]}}, prod});
            end
        end
`ifdef CONV_RELU_EN
        res_val = acc[19] ? 20'sd0 : acc;
`else
        res_val = acc;
`endif
    end

    // Pixel and result storage carry no reset; they are always fully
    // rewritten before being read.
    always_ff @(posedge clk) begin
        if (reset) begin
            if (capture) pix[pix_cnt] <= CONV_iData;
            if (state == CALC) res[out_cnt[3:0]] <= res_val;
        end
    end

    // out_cnt indexes the result being computed in CALC and the result being
    // streamed in OUT; the extra OUT cycle at count 16 drives the stream back
    // to zero as the block returns to IDLE.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pix_cnt     <= '0;
            out_cnt     <= '0;
            CONV_finish <= 1'b0;
            CONV_oData  <= '0;
        end else begin
            CONV_finish <= (state == FIN);
            CONV_oData  <= '0;
            case (state)
                IDLE, LOAD: begin
                    if (CONV_start) begin
                        pix_cnt <= (pix_cnt == 6'd35) ? 6'd0 : pix_cnt + 6'd1;
                    end
                end
                CALC: begin
                    out_cnt <= (out_cnt == 5'd15) ? 5'd0 : out_cnt + 5'd1;
                end
                OUT: begin
                    if (out_cnt == 5'd16) begin
                        out_cnt <= '0;
                    end else begin
                        CONV_oData <= res[out_cnt[3:0]];
                        out_cnt    <= out_cnt + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_conv.sv
// -----------------------------------------------------------------------------
// tb_conv : self-checking bench for conv.
//
// Two instances share clock, reset and pixel stream: dut_a uses the default
// kernel, dut_b uses all coefficients = -128 so the extreme-value sums can be
// exercised. Expected results come from a direct evaluation of the
// correlation formula over plain integer arrays, or from hand-derived
// constants for the named patterns.
// -----------------------------------------------------------------------------
module tb_conv;

    typedef int pix_t  [36];
    typedef int res_t  [16];
    typedef int kern_t [9];

    typedef struct {
        string name;
        pix_t  px;
        res_t  exp_a;
        res_t  exp_b;
        int    stall_after;
        int    stall_len;
        bit    extra;
    } vec_t;

    localparam int NV = 10;

    logic               clk = 1'b0;
    logic               reset;
    logic               conv_start;
    logic signed [7:0]  conv_idata;
    logic               finish_a;
    logic               finish_b;
    logic signed [19:0] odata_a;
    logic signed [19:0] odata_b;

    int    cyc;
    int    total;
    int    bad;
    vec_t  vecs [NV];
    kern_t ka = '{1, 0, -1, 2, 0, -2, 1, 0, -1};
    kern_t kb = '{default: -128};

    conv dut_a (
        .clk         (clk),
        .reset       (reset),
        .CONV_start  (conv_start),
        .CONV_iData  (conv_idata),
        .CONV_finish (finish_a),
        .CONV_oData  (odata_a)
    );

    conv #(
        .K11(8'sh80), .K12(8'sh80), .K13(8'sh80),
        .K21(8'sh80), .K22(8'sh80), .K23(8'sh80),
        .K31(8'sh80), .K32(8'sh80), .K33(8'sh80)
    ) dut_b (
        .clk         (clk),
        .reset       (reset),
        .CONV_start  (conv_start),
        .CONV_iData  (conv_idata),
        .CONV_finish (finish_b),
        .CONV_oData  (odata_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int clampv(input int v);
`ifdef CONV_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    // out[r][c] = sum K[m][n] * X[r+m][c+n] over the 3x3 window
    function automatic void model_conv(input pix_t px, input kern_t k, output res_t o);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                int s;
                s = 0;
                for (int m = 0; m < 3; m++)
                    for (int n = 0; n < 3; n++)
                        s += k[m * 3 + n] * px[(r + m) * 6 + (c + n)];
                o[r * 4 + c] = clampv(s);
            end
        end
    endfunction

    function automatic vec_t make_vec(input string name, input pix_t p,
                                      input int sa, input int sl, input bit ex);
        vec_t v;
        res_t t;
        v.name        = name;
        v.px          = p;
        v.stall_after = sa;
        v.stall_len   = sl;
        v.extra       = ex;
        model_conv(p, ka, t);
        v.exp_a = t;
        model_conv(p, kb, t);
        v.exp_b = t;
        return v;
    endfunction

    task automatic compareValue(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drives the 36 pixels, inserting the vector's stall, and returns the
    // cycle stamp of the first capturing edge.
    task automatic applyStimulus(input vec_t v, output int t0);
        t0 = 0;
        for (int i = 0; i < 36; i++) begin
            conv_start = 1'b1;
            conv_idata = 8'(v.px[i]);
            @(posedge clk); #1;
            if (i == 0) t0 = cyc;
            if ((i == v.stall_after) && (v.stall_len > 0)) begin
                conv_start = 1'b0;
                conv_idata = 8'($urandom);
                repeat (v.stall_len) begin
                    @(posedge clk); #1;
                end
            end
        end
        conv_start = v.extra;
        conv_idata = 8'($urandom);
    endtask

    // Waits (bounded) for the finish pulse, checks its position, then the
    // 16-word stream from both instances and the return to zero afterwards.
    task automatic checkOutput(input vec_t v, input int t0);
        bit seen;
        seen = 1'b0;
        for (int w = 0; (w < 100) && !seen; w++) begin
            @(posedge clk); #1;
            if (finish_a) seen = 1'b1;
            else if (v.extra) conv_idata = 8'($urandom);
        end
        conv_start = 1'b0;
        compareValue({v.name, " finish_latency"}, seen ? (cyc - t0) : -1, 52 + v.stall_len);
        if (!seen) return;
        compareValue({v.name, " finish_b"}, int'(finish_b), 1);
        compareValue({v.name, " odata_at_finish"}, int'(odata_a), 0);
        for (int k = 0; k < 16; k++) begin
            @(posedge clk); #1;
            compareValue($sformatf("%s out_a[%0d]", v.name, k), int'(odata_a), v.exp_a[k]);
            compareValue($sformatf("%s out_b[%0d]", v.name, k), int'(odata_b), v.exp_b[k]);
        end
        @(posedge clk); #1;
        compareValue({v.name, " odata_after_stream"}, int'(odata_b), 0);
        compareValue({v.name, " finish_after_stream"}, int'(finish_a), 0);
    endtask

    initial begin
        pix_t p;
        int   t0;
        bit   seen;

        total      = 0;
        bad        = 0;
        reset      = 1'b0;
        conv_start = 1'b0;
        conv_idata = '0;

        // Vector table
        for (int i = 0; i < 36; i++) p[i] = (i % 6) + 1;
        vecs[0] = make_vec("ramp", p, 0, 0, 1'b0);
        for (int k = 0; k < 16; k++) vecs[0].exp_a[k] = clampv(-8);

        p = '{default: 0};
        p[14] = 1;
        vecs[1] = make_vec("impulse", p, 0, 0, 1'b0);
        vecs[1].exp_a = '{default: 0};
        vecs[1].exp_a[0]  = clampv(-1);
        vecs[1].exp_a[2]  = clampv(1);
        vecs[1].exp_a[4]  = clampv(-2);
        vecs[1].exp_a[6]  = clampv(2);
        vecs[1].exp_a[8]  = clampv(-1);
        vecs[1].exp_a[10] = clampv(1);

        p = '{default: -128};
        vecs[2] = make_vec("neg_extreme", p, 0, 0, 1'b0);
        vecs[2].exp_a = '{default: 0};
        vecs[2].exp_b = '{default: 147456};

        p = '{default: 127};
        vecs[3] = make_vec("pos_extreme", p, 0, 0, 1'b1);
        vecs[3].exp_a = '{default: 0};
        for (int k = 0; k < 16; k++) vecs[3].exp_b[k] = clampv(-146304);

        p = '{default: 5};
        vecs[4] = make_vec("const5", p, 0, 0, 1'b0);
        vecs[4].exp_a = '{default: 0};

        for (int i = 0; i < 36; i++) p[i] = (i % 6) + 1;
        vecs[5] = make_vec("ramp_stall", p, 10, 3, 1'b0);
        for (int k = 0; k < 16; k++) vecs[5].exp_a[k] = clampv(-8);

        for (int v = 6; v < NV; v++) begin
            for (int i = 0; i < 36; i++) p[i] = int'($urandom_range(0, 255)) - 128;
            vecs[v] = make_vec($sformatf("random%0d", v), p,
                               int'($urandom_range(0, 34)), int'($urandom_range(0, 4)),
                               1'(v % 2));
        end

        // Reset held for two cycles
        repeat (2) @(posedge clk);
        #1;
        compareValue("reset finish_a", int'(finish_a), 0);
        compareValue("reset odata_a", int'(odata_a), 0);
        compareValue("reset finish_b", int'(finish_b), 0);
        compareValue("reset odata_b", int'(odata_b), 0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Abort a frame after 20 pixels; the next frame must start from pixel 0
        for (int i = 0; i < 20; i++) begin
            conv_start = 1'b1;
            conv_idata = 8'($urandom);
            @(posedge clk); #1;
        end
        conv_start = 1'b0;
        reset      = 1'b0;
        @(posedge clk); #1;
        compareValue("midload_reset finish", int'(finish_a), 0);
        compareValue("midload_reset odata", int'(odata_a), 0);
        reset = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < NV; v++) begin
            applyStimulus(vecs[v], t0);
            checkOutput(vecs[v], t0);
            @(posedge clk); #1;
        end

        // Reset in the middle of the result stream clears the output at once
        applyStimulus(vecs[2], t0);
        seen = 1'b0;
        for (int w = 0; (w < 100) && !seen; w++) begin
            @(posedge clk); #1;
            if (finish_a) seen = 1'b1;
        end
        compareValue("midstream finish_seen", int'(seen), 1);
        repeat (3) begin
            @(posedge clk); #1;
        end
        compareValue("midstream odata_b", int'(odata_b), 147456);
        reset = 1'b0;
        @(posedge clk); #1;
        compareValue("midstream_reset odata_b", int'(odata_b), 0);
        reset = 1'b1;
        @(posedge clk); #1;
        compareValue("midstream_idle odata_b", int'(odata_b), 0);
        applyStimulus(vecs[0], t0);
        checkOutput(vecs[0], t0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
